// File: rtl/npc_pkg.sv
// Shared npc definitions: register file geometry and write-back encodings.
package npc_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  // Register 0 reads as zero; writes to it never commit.
  localparam int unsigned ZERO_REG = 0;

  // Write-back arbiter state: the single ALU holding slot is empty or full.
  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_HOLD  = 1'b1
  } wb_state_e;

  // Which source drives the write bus this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_HOLD = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/rf_writeback_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue and
// cleared when the load's data is committed to the register file.
module wb_scoreboard
  import npc_pkg::*;
#(
  parameter int unsigned AW = ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [AW-1:0]         set_idx,
  input  logic                  clr_valid,
  input  logic [AW-1:0]         clr_idx,
  output logic [(1<<AW)-1:0]    pend
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [(1<<AW)-1:0] pend_q;
  logic [(1<<AW)-1:0] pend_d;

  // Clear first so a coincident set of the same index wins; bit 0 never sets.
  always_comb begin
    pend_d = pend_q;
    if (clr_valid) begin
      pend_d[clr_idx] = 1'b0;
    end
    if (set_valid && (set_idx != ZERO_IDX)) begin
      pend_d[set_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending vector register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/rf_writeback.sv
// Register file write-side front end: arbitrates ALU and LSU results onto the
// single write port, buffers one displaced ALU result, and tracks loads in flight.
module rf_writeback
  import npc_pkg::*;
#(
  parameter int unsigned AW = ADDR_WIDTH,
  parameter int unsigned DW = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [AW-1:0]         alu_rd,
  input  logic [DW-1:0]         alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [AW-1:0]         lsu_rd,
  input  logic [DW-1:0]         lsu_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [(1<<AW)-1:0]    pend,
  output logic                  rf_wen,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata
);

  // state    | meaning
  // WB_EMPTY | hold slot free, ALU may be accepted
  // WB_HOLD  | hold slot holds an ALU result displaced by an LSU write

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  wb_state_e       state_q, state_d;
  wb_src_e         sel_src;
  logic            lsu_acc, alu_acc, hold_load;

  logic [AW-1:0]   hold_rd_q;
  logic [DW-1:0]   hold_data_q;

  logic            wen_q, wen_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            src_lsu_q, src_lsu_d;

  assign lsu_acc = lsu_valid & lsu_ready;
  assign alu_acc = alu_valid & alu_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill on a collision, drain once the LSU lets go of the bus.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_EMPTY: if (lsu_acc && alu_acc) state_d = WB_HOLD;
      WB_HOLD:  if (!lsu_acc)           state_d = WB_EMPTY;
      default:                          state_d = WB_EMPTY;
    endcase
  end

  // Outputs: readies depend only on state and reset, never on any valid.
  always_comb begin
    lsu_ready = rst_n;
    alu_ready = rst_n & (state_q == WB_EMPTY);
    hold_load = 1'b0;
    sel_src   = SRC_NONE;
    if (lsu_acc) begin
      sel_src   = SRC_LSU;
      hold_load = alu_acc;
    end else if (state_q == WB_HOLD) begin
      sel_src   = SRC_HOLD;
    end else if (alu_acc) begin
      sel_src   = SRC_ALU;
    end
  end

  // Hold buffer captures the ALU result that lost the bus to the LSU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else if (hold_load) begin
      hold_rd_q   <= alu_rd;
      hold_data_q <= alu_data;
    end
  end

  // Write bus next value; index 0 still updates addr/data but never enables.
  always_comb begin
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    src_lsu_d = 1'b0;
    unique case (sel_src)
      SRC_LSU: begin
        waddr_d   = lsu_rd;
        wdata_d   = lsu_data;
        wen_d     = (lsu_rd != ZERO_IDX);
        src_lsu_d = 1'b1;
      end
      SRC_HOLD: begin
        waddr_d = hold_rd_q;
        wdata_d = hold_data_q;
        wen_d   = (hold_rd_q != ZERO_IDX);
      end
      SRC_ALU: begin
        waddr_d = alu_rd;
        wdata_d = alu_data;
        wen_d   = (alu_rd != ZERO_IDX);
      end
      default: ;
    endcase
  end

  // Registered write bus plus the tag saying the write came from the LSU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      src_lsu_q <= 1'b0;
    end else begin
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      src_lsu_q <= src_lsu_d;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  // A pending bit clears on the same edge the register file commits the load.
  wb_scoreboard #(.AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (issue_valid),
    .set_idx   (issue_rd),
    .clr_valid (wen_q & src_lsu_q),
    .clr_idx   (waddr_q),
    .pend      (pend)
  );

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] pend;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rf_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pend        (pend),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1'b1;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_wen",   rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pend",  pend, 0);
    chk("rst_alu_rdy", alu_ready, 0);
    chk("rst_lsu_rdy", lsu_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_alu_rdy", alu_ready, 1);
    chk("rel_lsu_rdy", lsu_ready, 1);

    // ALU only
    drive_alu(5'd3, 32'hDEADBEEF);
    tick();
    idle();
    chk("alu_wen",   rf_wen, 1);
    chk("alu_waddr", rf_waddr, 3);
    chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    chk("alu_wen_off", rf_wen, 0);
    chk("idle_waddr_hold", rf_waddr, 3);
    chk("idle_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Collision
    drive_alu(5'd4, 32'h11);
    drive_lsu(5'd5, 32'h22);
    tick();
    idle();
    chk("col1_wen",   rf_wen, 1);
    chk("col1_waddr", rf_waddr, 5);
    chk("col1_wdata", rf_wdata, 32'h22);
    chk("col1_alu_rdy", alu_ready, 0);
    tick();
    chk("col2_wen",   rf_wen, 1);
    chk("col2_waddr", rf_waddr, 4);
    chk("col2_wdata", rf_wdata, 32'h11);
    chk("col2_alu_rdy", alu_ready, 1);
    tick();
    chk("col3_wen", rf_wen, 0);

    // LSU streaming over a full hold slot
    drive_alu(5'd4, 32'h44);
    drive_lsu(5'd5, 32'h55);
    tick();
    idle();
    chk("str_n1_waddr", rf_waddr, 5);
    drive_lsu(5'd8, 32'hA8);
    tick();
    chk("str_n2_waddr", rf_waddr, 8);
    chk("str_n2_wdata", rf_wdata, 32'hA8);
    chk("str_n2_alu_rdy", alu_ready, 0);
    drive_lsu(5'd9, 32'hA9);
    tick();
    chk("str_n3_waddr", rf_waddr, 9);
    drive_lsu(5'd10, 32'hAA);
    tick();
    chk("str_n4_waddr", rf_waddr, 10);
    chk("str_n4_wdata", rf_wdata, 32'hAA);
    chk("str_n4_alu_rdy", alu_ready, 0);
    idle();
    tick();
    chk("str_n5_wen",   rf_wen, 1);
    chk("str_n5_waddr", rf_waddr, 4);
    chk("str_n5_wdata", rf_wdata, 32'h44);
    chk("str_n5_alu_rdy", alu_ready, 1);
    tick();

    // Scoreboard set / clear
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    idle();
    chk("sb_set", pend, 32'h80);
    tick();
    tick();
    drive_lsu(5'd7, 32'h77);
    tick();
    idle();
    chk("sb_wen", rf_wen, 1);
    chk("sb_waddr", rf_waddr, 7);
    chk("sb_pend_still", pend, 32'h80);
    tick();
    chk("sb_clear", pend, 0);

    // Set coinciding with the clearing edge wins
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    idle();
    chk("sb2_set", pend, 32'h80);
    drive_lsu(5'd7, 32'h78);
    tick();
    idle();
    chk("sb2_wen", rf_wen, 1);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    idle();
    chk("sb2_set_wins", pend, 32'h80);

    // ALU write to a pending register does not clear it
    drive_alu(5'd7, 32'h1234);
    tick();
    idle();
    chk("sb_alu_wen", rf_wen, 1);
    tick();
    chk("sb_alu_noclr", pend, 32'h80);
    drive_lsu(5'd7, 32'h79);
    tick();
    idle();
    tick();
    chk("sb3_clear", pend, 0);

    // Index 0
    drive_alu(5'd0, 32'hFFFF);
    #1;
    chk("z_alu_rdy", alu_ready, 1);
    tick();
    idle();
    chk("z_wen",   rf_wen, 0);
    chk("z_waddr", rf_waddr, 0);
    chk("z_wdata", rf_wdata, 32'hFFFF);
    chk("z_alu_rdy_after", alu_ready, 1);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    idle();
    chk("z_pend", pend, 0);

    // Reset mid-operation with hold full and pend[5]=1
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    idle();
    drive_alu(5'd6, 32'h66);
    drive_lsu(5'd9, 32'h99);
    tick();
    alu_valid = 1'b0;
    chk("mr_pend_pre", pend, 32'h20);
    chk("mr_hold_full", alu_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_alu_rdy", alu_ready, 0);
    chk("mr_lsu_rdy", lsu_ready, 0);
    tick();
    tick();
    chk("mr_wen",   rf_wen, 0);
    chk("mr_waddr", rf_waddr, 0);
    chk("mr_wdata", rf_wdata, 0);
    chk("mr_pend",  pend, 0);
    idle();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_alu_rdy", alu_ready, 1);
    tick();
    chk("mr_no_drain", rf_wen, 0);
    chk("mr_no_drain_addr", rf_waddr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side front end for the integer register file: merges results from the single-cycle ALU path and the multi-cycle LSU load path into the register file's single write port (wen/waddr/wdata). Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards against outstanding loads. Sits between execute/LSU and the register file, which commits on the next clk edge and returns zero for reads of address 0.

## Interface
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous and active-low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted when alu_valid & alu_ready.
- alu_rd  in  ADDR_WIDTH  ALU destination index.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted when lsu_valid & lsu_ready.
- lsu_rd  in  ADDR_WIDTH  load destination index.
- lsu_data  in  DATA_WIDTH  load data.
- issue_valid  in  1  decode issues a load this cycle.
- issue_rd  in  ADDR_WIDTH  destination of that load.
- pend  out  2**ADDR_WIDTH  bit i = load to register i outstanding.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write index.
- rf_wdata  out  DATA_WIDTH  register file write data.

## Operation
- Two states via hold_full flag: EMPTY, HOLD (one-entry ALU holding buffer: hold_rd, hold_data).
- lsu_ready = rst_n (LSU always accepted outside reset; it has priority).
- alu_ready = rst_n & ~hold_full; depends on state only, no combinational path from any valid.
- Per-cycle write-bus selection, priority order: accepted LSU > hold buffer > accepted ALU.
- EMPTY, ALU and LSU both accepted: LSU drives write bus; ALU captured in hold -> HOLD.
- HOLD, lsu_valid: LSU drives write bus; hold unchanged, stay HOLD.
- HOLD, ~lsu_valid: hold drives write bus -> EMPTY. No ALU accepted that cycle (alu_ready was 0).
- Index 0: selected write completes its handshake/drain normally but rf_wen = 0; rf_waddr/rf_wdata still update.
- Nothing selected: rf_wen = 0; rf_waddr/rf_wdata hold previous values.
- Scoreboard set: issue_valid & issue_rd != 0 sets pend[issue_rd] at next edge.
- Scoreboard clear: pend[rf_waddr] cleared on the edge where rf_wen is high for a write originating from the LSU (registered source tag), i.e., the same edge the register file commits the data.
- Simultaneous set and clear of the same index: set wins (pend stays 1).
- pend[0] is constant 0.
- Decode contract: stall any instruction whose rs or rd has pend set; therefore ALU and LSU never target the same register out of order, and write order between them carries no meaning.

## Timing
- Reset (rst_n low at an edge): rf_wen=0, rf_waddr=0, rf_wdata=0, pend=0, hold_full=0; alu_ready=lsu_ready=0 while rst_n low. Reset mid-operation discards the hold entry and all pending bits.
- Write bus registered: handshake at cycle N -> rf_wen/rf_waddr/rf_wdata at N+1 -> register file content visible at N+2.
- Held ALU result: earliest write bus at N+2, delayed further for each consecutive cycle lsu_valid stays high.
- pend set: issue at N -> pend bit high from N+1.
- pend clear: LSU accepted at N -> rf_wen at N+1 -> pend bit low from N+2, concurrent with register file update; no bypass needed.
- Throughput: one register file write per cycle; ALU stalls at most while HOLD persists.

## Structure
- ADDR_WIDTH/DATA_WIDTH defaults and the zero-register index constant belong in the shared npc definitions package, also used by the register file and decode.
- One natural sub-module: wb_scoreboard (pend vector, set/clear/priority logic); arbitration and hold buffer stay in rf_writeback.

## Test plan
- Reset: traffic running with hold full and pend[5]=1, drive rst_n=0 for 2 cycles -> rf_wen=0, rf_waddr=0, rf_wdata=0, pend=0, both readys 0; after release alu_ready=1.
- ALU only: alu rd=3 data 0xDEADBEEF at N -> rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF at N+1 only; rf_wen=0 at N+2.
- Collision: alu rd=4 0x11 and lsu rd=5 0x22 at N -> write x5/0x22 at N+1, alu_ready=0 at N+1, write x4/0x11 at N+2, alu_ready=1 at N+2.
- LSU streaming over HOLD: collision at N, then lsu_valid held high N+1..N+3 -> three LSU writes N+2..N+4, held x4 written at N+5.
- Scoreboard: issue rd=7 at N -> pend[7]=1 at N+1; lsu rd=7 at N+3 -> rf_wen at N+4, pend[7]=0 at N+5; repeat with issue rd=7 coinciding with the clearing edge -> pend[7] stays 1.
- Index 0: alu rd=0 0xFFFF at N -> handshake completes, rf_wen stays 0; issue rd=0 -> pend unchanged (all 0).
